// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and constants for the 4-way round-robin burst arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package mux4_rr_arbiter_pkg;

   localparam int NREQ = 4;

   typedef enum logic {IDLE, BUSY} arb_state_t;

   // One-hot decode of a requester index.
   function automatic logic [NREQ-1:0] onehot_idx(input logic [1:0] idx);
      return NREQ'(1) << idx;
   endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux4.sv
// Plain 4:1 data multiplexer selecting one requester's data word.
// Latency: purely combinational.
// Backpressure: none; follows sel directly.
module mux4 #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   input  logic [WIDTH-1:0] d3,
   input  logic [1:0]       sel,
   output logic [WIDTH-1:0] y
);

   // Select the data word of the requester indexed by sel.
   always_comb begin
      y = d0;
      case (sel)
         2'd0: y = d0;
         2'd1: y = d1;
         2'd2: y = d2;
         2'd3: y = d3;
         default: y = d0;
      endcase
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin, burst-locking arbiter sharing one WIDTH-bit datapath between 4 requesters.
// Latency: request -> grant on next edge, first beat may transfer in that cycle; one idle bubble between grants.
// Backpressure: out_ready low holds state/beat count and deasserts every in_ready.
module mux4_rr_arbiter
   import mux4_rr_arbiter_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       in_valid,
   input  logic [3:0]       in_last,
   input  logic [WIDTH-1:0] din1,
   input  logic [WIDTH-1:0] din2,
   input  logic [WIDTH-1:0] din3,
   input  logic [WIDTH-1:0] din4,
   output logic [3:0]       in_ready,
   output logic             out_valid,
   output logic             out_last,
   input  logic             out_ready,
   output logic [WIDTH-1:0] dout,
   output logic [1:0]       grant,
   output logic             busy
);

   localparam int CW = $clog2(MAX_BURST + 1);

   arb_state_t      state_q, state_d;
   logic [1:0]      grant_q, grant_d;
   logic [1:0]      rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

   logic [NREQ-1:0] rot_req;
   logic [1:0]      pick_off;
   logic [1:0]      pick_idx;
   logic            at_max;
   logic            xfer;
   logic            owner_last;

   // Round-robin pick: rotate requests so rr_ptr sits at bit 0, take lowest set bit, rotate back.
   always_comb begin
      rot_req  = NREQ'({in_valid, in_valid} >> rr_ptr_q);
      pick_off = 2'd0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (rot_req[i]) pick_off = 2'(i);
      end
      pick_idx = rr_ptr_q + pick_off;
   end

   // Handshake gating: only the owner sees ready, and only while the consumer is ready.
   always_comb begin
      busy       = (state_q == BUSY);
      grant      = grant_q;
      at_max     = (beat_cnt_q == CW'(MAX_BURST - 1));
      owner_last = in_last[grant_q];
      out_valid  = busy && in_valid[grant_q];
      out_last   = out_valid && (owner_last || at_max);
      in_ready   = busy ? (onehot_idx(grant_q) & {NREQ{out_ready}}) : '0;
      xfer       = out_valid && out_ready;
   end

   // Next-state: grant on request in IDLE, count beats and release on last or burst limit in BUSY.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      case (state_q)
         IDLE: begin
            if (|in_valid) begin
               grant_d    = pick_idx;
               beat_cnt_d = '0;
               state_d    = BUSY;
            end
         end
         BUSY: begin
            if (xfer) begin
               if (owner_last || at_max) begin
                  state_d    = IDLE;
                  rr_ptr_d   = grant_q + 2'd1;
                  beat_cnt_d = '0;
               end else begin
                  beat_cnt_d = beat_cnt_q + CW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Arbiter state registers; reset abandons any partial burst immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         grant_q    <= 2'd0;
         rr_ptr_q   <= 2'd0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   mux4 #(.WIDTH(WIDTH)) u_mux4 (
      .d0  (din1),
      .d1  (din2),
      .d2  (din3),
      .d3  (din4),
      .sel (grant_q),
      .y   (dout)
   );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] in_valid, in_last, in_ready;
   logic [7:0] din1, din2, din3, din4, dout;
   logic       out_valid, out_last, out_ready, busy;
   logic [1:0] grant;

   int tests = 0;
   int fails = 0;

   // {busy, out_valid, out_last, in_ready}
   logic [6:0] obs;
   logic [6:0] exp_o;
   assign obs = {busy, out_valid, out_last, in_ready};

   always #5 clk = ~clk;

   mux4_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .din1      (din1),
      .din2      (din2),
      .din3      (din3),
      .din4      (din4),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_ready (out_ready),
      .dout      (dout),
      .grant     (grant),
      .busy      (busy)
   );

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 4'b0; in_last = 4'b0; out_ready = 1'b0;
      din1 = 8'h11; din2 = 8'h22; din3 = 8'hA5; din4 = 8'h44;
      #3;
      exp_o = 7'b0;
      tests++; if (obs !== exp_o) begin fails++; $display("FAIL reset_ctl got %b exp %b", obs, exp_o); end
      tests++; if (grant !== 2'd0) begin fails++; $display("FAIL reset_grant got %0d exp 0", grant); end
      tests++; if (dout !== 8'h11) begin fails++; $display("FAIL reset_dout got %h exp 11", dout); end
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic test_fairness;
      in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         exp_o = {1'b1, 1'b1, 1'b1, 4'(1) << (k % 4)};
         tests++; if (obs !== exp_o) begin fails++; $display("FAIL fair_ctl[%0d] got %b exp %b", k, obs, exp_o); end
         tests++; if (grant !== 2'(k % 4)) begin fails++; $display("FAIL fair_grant[%0d] got %0d exp %0d", k, grant, k % 4); end
         tick();
         tests++; if (busy !== 1'b0) begin fails++; $display("FAIL fair_idle[%0d] got %b exp 0", k, busy); end
      end
      in_valid = 4'b0; in_last = 4'b0;
   endtask

   task automatic test_single;
      in_valid = 4'b0100; in_last = 4'b0100; out_ready = 1'b1;
      #1;
      exp_o = 7'b0;
      tests++; if (obs !== exp_o) begin fails++; $display("FAIL single_idle got %b exp %b", obs, exp_o); end
      tick();
      exp_o = {1'b1, 1'b1, 1'b1, 4'b0100};
      tests++; if (obs !== exp_o) begin fails++; $display("FAIL single_ctl got %b exp %b", obs, exp_o); end
      tests++; if (grant !== 2'd2) begin fails++; $display("FAIL single_grant got %0d exp 2", grant); end
      tests++; if (dout !== 8'hA5) begin fails++; $display("FAIL single_dout got %h exp a5", dout); end
      tick();
      in_valid = 4'b0; in_last = 4'b0;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_release got %b exp 0", busy); end
   endtask

   task automatic test_wrap;
      in_valid = 4'b1001; in_last = 4'b1001; out_ready = 1'b1;
      tick();
      exp_o = {1'b1, 1'b1, 1'b1, 4'b1000};
      tests++; if (obs !== exp_o) begin fails++; $display("FAIL wrap3_ctl got %b exp %b", obs, exp_o); end
      tests++; if (grant !== 2'd3) begin fails++; $display("FAIL wrap3_grant got %0d exp 3", grant); end
      tests++; if (dout !== 8'h44) begin fails++; $display("FAIL wrap3_dout got %h exp 44", dout); end
      tick();
      in_valid = 4'b0001;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL wrap_idle got %b exp 0", busy); end
      tick();
      exp_o = {1'b1, 1'b1, 1'b1, 4'b0001};
      tests++; if (obs !== exp_o) begin fails++; $display("FAIL wrap0_ctl got %b exp %b", obs, exp_o); end
      tests++; if (grant !== 2'd0) begin fails++; $display("FAIL wrap0_grant got %0d exp 0", grant); end
      tests++; if (dout !== 8'h11) begin fails++; $display("FAIL wrap0_dout got %h exp 11", dout); end
      tick();
      in_valid = 4'b0; in_last = 4'b0;
   endtask

   task automatic test_forced_release;
      in_valid = 4'b0110; in_last = 4'b0000; out_ready = 1'b1;
      for (int b = 0; b < 4; b++) begin
         tick();
         exp_o = {1'b1, 1'b1, (b == 3), 4'b0010};
         tests++; if (obs !== exp_o) begin fails++; $display("FAIL forced_beat%0d got %b exp %b", b, obs, exp_o); end
         tests++; if (grant !== 2'd1 || dout !== 8'h22) begin fails++; $display("FAIL forced_owner%0d got %0d/%h exp 1/22", b, grant, dout); end
      end
      tick();
      in_valid = 4'b0100; in_last = 4'b0100;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL forced_release got %b exp 0", busy); end
      tick();
      exp_o = {1'b1, 1'b1, 1'b1, 4'b0100};
      tests++; if (obs !== exp_o) begin fails++; $display("FAIL forced_next_ctl got %b exp %b", obs, exp_o); end
      tests++; if (grant !== 2'd2) begin fails++; $display("FAIL forced_next_grant got %0d exp 2", grant); end
      tick();
      in_valid = 4'b0; in_last = 4'b0;
   endtask

   task automatic test_backpressure;
      in_valid = 4'b1000; in_last = 4'b0000; out_ready = 1'b1;
      tick();
      exp_o = {1'b1, 1'b1, 1'b0, 4'b1000};
      tests++; if (obs !== exp_o || grant !== 2'd3) begin fails++; $display("FAIL bp_first got %b/%0d exp %b/3", obs, grant, exp_o); end
      tick();
      out_ready = 1'b0;
      #1;
      for (int s = 0; s < 4; s++) begin
         exp_o = {1'b1, 1'b1, 1'b0, 4'b0000};
         tests++; if (obs !== exp_o) begin fails++; $display("FAIL bp_stall%0d got %b exp %b", s, obs, exp_o); end
         tests++; if (dout !== 8'h44) begin fails++; $display("FAIL bp_dout%0d got %h exp 44", s, dout); end
         if (s < 3) tick();
      end
      out_ready = 1'b1;
      #1;
      exp_o = {1'b1, 1'b1, 1'b0, 4'b1000};
      tests++; if (obs !== exp_o) begin fails++; $display("FAIL bp_resume1 got %b exp %b", obs, exp_o); end
      tick();
      tests++; if (obs !== exp_o) begin fails++; $display("FAIL bp_resume2 got %b exp %b", obs, exp_o); end
      tick();
      exp_o = {1'b1, 1'b1, 1'b1, 4'b1000};
      tests++; if (obs !== exp_o) begin fails++; $display("FAIL bp_resume3 got %b exp %b", obs, exp_o); end
      tick();
      in_valid = 4'b0;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL bp_release got %b exp 0", busy); end
   endtask

   task automatic test_async_reset;
      in_valid = 4'b0010; in_last = 4'b0000; out_ready = 1'b1;
      tick();
      exp_o = {1'b1, 1'b1, 1'b0, 4'b0010};
      tests++; if (obs !== exp_o || grant !== 2'd1) begin fails++; $display("FAIL arst_pre got %b/%0d exp %b/1", obs, grant, exp_o); end
      tick();
      #1 rst_n = 1'b0;
      #1;
      exp_o = 7'b0;
      tests++; if (obs !== exp_o) begin fails++; $display("FAIL arst_ctl got %b exp %b", obs, exp_o); end
      tests++; if (grant !== 2'd0) begin fails++; $display("FAIL arst_grant got %0d exp 0", grant); end
      tick();
      tests++; if (obs !== exp_o) begin fails++; $display("FAIL arst_held got %b exp %b", obs, exp_o); end
      rst_n = 1'b1;
      for (int b = 0; b < 4; b++) begin
         tick();
         exp_o = {1'b1, 1'b1, (b == 3), 4'b0010};
         tests++; if (obs !== exp_o) begin fails++; $display("FAIL arst_beat%0d got %b exp %b", b, obs, exp_o); end
      end
      tick();
      in_valid = 4'b0;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL arst_release got %b exp 0", busy); end
   endtask

   initial begin
      test_reset();
      test_fairness();
      test_single();
      test_wrap();
      test_forced_release();
      test_backpressure();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
